arrow_lane_scroller: RTL and testbench

// - Per-player arrow playfield engine: owns the 26-slot arrow column that drives the display colour-index stage.
// - Scrolls arrows downward at a fixed step rate and loads new arrows from the chart sequencer at the top slot.
// - Judges button presses against the hit window and drives the judgement indicator, score and combo.
// - One instance per player. p1 outputs and p2 outputs each feed the display colour-index stage.

---
 rtl/dance_pkg.sv | 57 +++++
 rtl/arrow_step_timer.sv | 34 +++
 rtl/arrow_lane_scroller.sv | 149 ++++++++++++++
 tb/tb_arrow_lane_scroller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dance_pkg.sv
// Shared constants for the dance playfield: lane codes, judgement indicator
// codes, column geometry and the palette indices used by the display stage.
package dance_pkg;

  localparam int NUM_SLOTS = 26;
  localparam int ARROW_W   = 3;
  localparam int ARRAY_W   = NUM_SLOTS * ARROW_W;

  localparam logic [2:0] LANE_EMPTY = 3'b000;
  localparam logic [2:0] LANE_UP    = 3'b001;
  localparam logic [2:0] LANE_LEFT  = 3'b010;
  localparam logic [2:0] LANE_DOWN  = 3'b011;
  localparam logic [2:0] LANE_RIGHT = 3'b100;
  localparam logic [2:0] LANE_SHAKE = 3'b110;

  localparam logic [1:0] IND_NONE      = 2'b00;
  localparam logic [1:0] IND_BAD       = 2'b01;
  localparam logic [1:0] IND_GOOD      = 2'b10;
  localparam logic [1:0] IND_EXCELLENT = 2'b11;

  localparam logic [3:0] COLOUR_BACKGROUND = 4'h0;
  localparam logic [3:0] COLOUR_UP         = 4'h1;
  localparam logic [3:0] COLOUR_LEFT       = 4'h2;
  localparam logic [3:0] COLOUR_DOWN       = 4'h3;
  localparam logic [3:0] COLOUR_RIGHT      = 4'h4;
  localparam logic [3:0] COLOUR_SHAKE      = 4'h5;
  localparam logic [3:0] COLOUR_HIT_ZONE   = 4'h6;
  localparam logic [3:0] COLOUR_EXCELLENT  = 4'h7;
  localparam logic [3:0] COLOUR_GOOD       = 4'h8;
  localparam logic [3:0] COLOUR_BAD        = 4'h9;

  // Codes 101 and 111 are unused by the chart format and load as empty.
  function automatic logic [2:0] lane_load(input logic [2:0] code);
    return (code == 3'b101 || code == 3'b111) ? LANE_EMPTY : code;
  endfunction

  function automatic logic [3:0] lane_colour(input logic [2:0] code);
    case (code)
      LANE_UP:    return COLOUR_UP;
      LANE_LEFT:  return COLOUR_LEFT;
      LANE_DOWN:  return COLOUR_DOWN;
      LANE_RIGHT: return COLOUR_RIGHT;
      LANE_SHAKE: return COLOUR_SHAKE;
      default:    return COLOUR_BACKGROUND;
    endcase
  endfunction

  function automatic logic [3:0] indicator_colour(input logic [1:0] ind);
    case (ind)
      IND_EXCELLENT: return COLOUR_EXCELLENT;
      IND_GOOD:      return COLOUR_GOOD;
      IND_BAD:       return COLOUR_BAD;
      default:       return COLOUR_BACKGROUND;
    endcase
  endfunction

endpackage

// File: rtl/arrow_step_timer.sv
// Free-running step divider: pulses step once every TICKS_PER_STEP enabled
// cycles. Also used by the chart sequencer for its own timing.
module arrow_step_timer #(
  parameter int TICKS_PER_STEP = 2_500_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic step
);

  localparam int CNT_W = (TICKS_PER_STEP > 2) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TICKS_PER_STEP - 1);

  logic [CNT_W-1:0] count;
  logic             at_terminal;

  assign at_terminal = (count == TERMINAL);

  // Counter freezes while disabled so a paused game resumes mid-step.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_terminal ? '0 : count + 1'b1;
    end
  end

  assign step = enable && at_terminal && !clear;

endmodule

// File: rtl/arrow_lane_scroller.sv
// Per-player arrow column: scrolls chart arrows toward the hit zone at the
// bottom, judges presses against slots 25/24/23 and tracks score and combo.
module arrow_lane_scroller #(
  parameter int TICKS_PER_STEP = 2_500_000,
  parameter int INDICATOR_HOLD = 12_500_000,
  parameter int NUM_SLOTS      = dance_pkg::NUM_SLOTS
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   chart_valid,
  input  logic [2:0]             chart_arrow,
  output logic                   chart_ready,
  input  logic                   press_valid,
  input  logic [2:0]             press_lane,
  output logic [3*NUM_SLOTS-1:0] arrow_array,
  output logic [1:0]             indicator,
  output logic [15:0]            score,
  output logic [7:0]             combo
);

  import dance_pkg::ARROW_W;
  import dance_pkg::LANE_EMPTY;
  import dance_pkg::IND_NONE;
  import dance_pkg::IND_BAD;
  import dance_pkg::IND_GOOD;
  import dance_pkg::IND_EXCELLENT;
  import dance_pkg::lane_load;

  localparam int BOT    = NUM_SLOTS - 1;
  localparam int HOLD_W = $clog2(INDICATOR_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(INDICATOR_HOLD);

  logic [NUM_SLOTS-1:0][ARROW_W-1:0] slots;
  logic [NUM_SLOTS-1:0][ARROW_W-1:0] cleared;
  logic [NUM_SLOTS-1:0][ARROW_W-1:0] slots_next;
  logic [HOLD_W-1:0]                 hold;

  logic       step;
  logic       press_live;
  logic       hit_exc;
  logic       hit_g1;
  logic       hit_g2;
  logic       hit_good;
  logic       press_bad;
  logic       miss;
  logic       judged;
  logic [1:0] ind_next;
  logic [15:0] score_next;
  logic [7:0]  combo_next;
  logic [7:0]  combo_base;
  logic [7:0]  combo_inc;
  logic [15:0] score_plus3;
  logic [15:0] score_plus1;

  arrow_step_timer #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_step_timer (
    .clock (clock),
    .resetn(resetn),
    .clear (clear),
    .enable(enable),
    .step  (step)
  );

  // Window search runs on the pre-step array; the bottom slot wins over the
  // two good slots, and slot 24 wins over slot 23.
  assign press_live = enable && press_valid && (press_lane != LANE_EMPTY);
  assign hit_exc    = press_live && (slots[BOT] == press_lane);
  assign hit_g1     = press_live && !hit_exc && (slots[BOT-1] == press_lane);
  assign hit_g2     = press_live && !hit_exc && !hit_g1 && (slots[BOT-2] == press_lane);
  assign hit_good   = hit_g1 || hit_g2;
  assign press_bad  = press_live && !hit_exc && !hit_good;
  assign miss       = step && (slots[BOT] != LANE_EMPTY) && !hit_exc;
  assign judged     = miss || press_live;

  assign score_plus3 = (score > 16'hFFFC) ? 16'hFFFF : score + 16'd3;
  assign score_plus1 = (score == 16'hFFFF) ? 16'hFFFF : score + 16'd1;
  assign combo_base  = miss ? 8'd0 : combo;
  assign combo_inc   = (combo_base == 8'hFF) ? 8'hFF : combo_base + 8'd1;

  always_comb begin
    cleared = slots;
    if (hit_exc) cleared[BOT]   = LANE_EMPTY;
    if (hit_g1)  cleared[BOT-1] = LANE_EMPTY;
    if (hit_g2)  cleared[BOT-2] = LANE_EMPTY;
    slots_next = cleared;
    if (step) begin
      slots_next = {cleared[NUM_SLOTS-2:0], (chart_valid ? lane_load(chart_arrow) : LANE_EMPTY)};
    end
  end

  // A miss on the step lands first, so a simultaneous hit restarts combo at 1.
  always_comb begin
    ind_next   = indicator;
    score_next = score;
    combo_next = combo;
    if (miss) begin
      ind_next   = IND_BAD;
      combo_next = 8'd0;
    end
    if (hit_exc) begin
      ind_next   = IND_EXCELLENT;
      score_next = score_plus3;
      combo_next = combo_inc;
    end else if (hit_good) begin
      ind_next   = IND_GOOD;
      score_next = score_plus1;
      combo_next = combo_inc;
    end else if (press_bad) begin
      ind_next   = IND_BAD;
      combo_next = 8'd0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      slots       <= '0;
      chart_ready <= 1'b0;
      indicator   <= IND_NONE;
      score       <= '0;
      combo       <= '0;
      hold        <= '0;
    end else if (clear) begin
      slots       <= '0;
      chart_ready <= 1'b0;
      indicator   <= IND_NONE;
      score       <= '0;
      combo       <= '0;
      hold        <= '0;
    end else begin
      slots       <= slots_next;
      chart_ready <= step && chart_valid;
      score       <= score_next;
      combo       <= combo_next;
      if (judged) begin
        indicator <= ind_next;
        hold      <= HOLD_RELOAD;
      end else if (hold != '0) begin
        hold <= hold - 1'b1;
        if (hold == HOLD_W'(1)) indicator <= IND_NONE;
      end
    end
  end

  assign arrow_array = slots;

endmodule

// File: tb/tb_arrow_lane_scroller.sv
// Scoreboard bench for arrow_lane_scroller: a lane-list reference model
// predicts each cycle's outputs, a monitor compares them after the edge.
module tb_arrow_lane_scroller;

  localparam int TPS  = 4;
  localparam int HOLD = 8;
  localparam int NS   = 26;

  logic        clock = 1'b0;
  logic        resetn;
  logic        clear;
  logic        enable;
  logic        chart_valid;
  logic [2:0]  chart_arrow;
  logic        chart_ready;
  logic        press_valid;
  logic [2:0]  press_lane;
  logic [77:0] arrow_array;
  logic [1:0]  indicator;
  logic [15:0] score;
  logic [7:0]  combo;

  typedef struct {
    logic [77:0] arr;
    logic [1:0]  ind;
    logic [15:0] score;
    logic [7:0]  combo;
    logic        ready;
  } exp_t;

  exp_t expQ[$];
  int errors = 0;
  int checks = 0;

  int lanes[NS];
  int stepCnt, holdLeft, mInd, mScore, mCombo;
  bit mReady;

  arrow_lane_scroller #(
    .TICKS_PER_STEP(TPS),
    .INDICATOR_HOLD(HOLD),
    .NUM_SLOTS(NS)
  ) dut (
    .clock(clock), .resetn(resetn), .clear(clear), .enable(enable),
    .chart_valid(chart_valid), .chart_arrow(chart_arrow), .chart_ready(chart_ready),
    .press_valid(press_valid), .press_lane(press_lane), .arrow_array(arrow_array),
    .indicator(indicator), .score(score), .combo(combo)
  );

  always #5 clock = ~clock;

  task automatic modelReset();
    foreach (lanes[i]) lanes[i] = 0;
    stepCnt = 0; holdLeft = 0; mInd = 0; mScore = 0; mCombo = 0; mReady = 0;
  endtask

  // One clock of game rules, written as "what the player sees happen".
  task automatic modelCycle(input bit en, input bit cv, input int ca, input bit pv, input int pl);
    bit stepNow, pressLive, judged;
    int hitSlot;
    stepNow = en && (stepCnt == TPS - 1);
    if (en) stepCnt = (stepCnt + 1) % TPS;
    pressLive = en && pv && (pl != 0);
    judged = 0;
    hitSlot = -1;
    if (pressLive) begin
      if (lanes[25] == pl) hitSlot = 25;
      else if (lanes[24] == pl) hitSlot = 24;
      else if (lanes[23] == pl) hitSlot = 23;
    end
    if (stepNow && lanes[25] != 0 && hitSlot != 25) begin
      mCombo = 0; mInd = 1; judged = 1;
    end
    if (pressLive) begin
      judged = 1;
      if (hitSlot == 25) begin
        mScore = (mScore + 3 > 65535) ? 65535 : mScore + 3;
        mCombo = (mCombo + 1 > 255) ? 255 : mCombo + 1;
        mInd = 3;
      end else if (hitSlot >= 0) begin
        mScore = (mScore + 1 > 65535) ? 65535 : mScore + 1;
        mCombo = (mCombo + 1 > 255) ? 255 : mCombo + 1;
        mInd = 2;
      end else begin
        mCombo = 0; mInd = 1;
      end
      if (hitSlot >= 0) lanes[hitSlot] = 0;
    end
    if (judged) holdLeft = HOLD;
    else if (holdLeft > 0) begin
      holdLeft--;
      if (holdLeft == 0) mInd = 0;
    end
    mReady = stepNow && cv;
    if (stepNow) begin
      for (int i = NS - 1; i > 0; i--) lanes[i] = lanes[i-1];
      lanes[0] = (!cv || ca == 5 || ca == 7) ? 0 : ca;
    end
  endtask

  task automatic applyStimulus(input bit rstn, input bit clr, input bit en, input bit cv,
                               input logic [2:0] ca, input bit pv, input logic [2:0] pl);
    exp_t e;
    @(negedge clock);
    resetn = rstn; clear = clr; enable = en; chart_valid = cv;
    chart_arrow = ca; press_valid = pv; press_lane = pl;
    if (!rstn || clr) modelReset();
    else modelCycle(en, cv, int'(ca), pv, int'(pl));
    for (int i = 0; i < NS; i++) e.arr[3*i +: 3] = 3'(lanes[i]);
    e.ind = 2'(mInd); e.score = 16'(mScore); e.combo = 8'(mCombo); e.ready = mReady;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks += 5;
    if (arrow_array !== e.arr) begin
      errors++; $display("[TB] FAIL arrow_array got %h want %h", arrow_array, e.arr);
    end
    if (indicator !== e.ind) begin
      errors++; $display("[TB] FAIL indicator got %b want %b at %0t", indicator, e.ind, $time);
    end
    if (score !== e.score) begin
      errors++; $display("[TB] FAIL score got %0d want %0d at %0t", score, e.score, $time);
    end
    if (combo !== e.combo) begin
      errors++; $display("[TB] FAIL combo got %0d want %0d at %0t", combo, e.combo, $time);
    end
    if (chart_ready !== e.ready) begin
      errors++; $display("[TB] FAIL chart_ready got %b want %b at %0t", chart_ready, e.ready, $time);
    end
  endtask

  always begin
    @(posedge clock);
    #1;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic idle(input int n);
    repeat (n) applyStimulus(1, 0, 1, 0, 3'b000, 0, 3'b000);
  endtask

  task automatic loadArrow(input logic [2:0] code);
    bit done = 0;
    repeat (2 * TPS) if (!done) begin
      applyStimulus(1, 0, 1, 1, code, 0, 3'b000);
      done = mReady;
    end
  endtask

  task automatic waitSlot(input int slot, input int code);
    repeat (30 * TPS) if (lanes[slot] != code) idle(1);
  endtask

  initial begin
    logic [2:0] ca, pl;
    bit en, cv, pv;
    resetn = 0; clear = 0; enable = 0; chart_valid = 0; chart_arrow = 0;
    press_valid = 0; press_lane = 0;
    modelReset();
    $display("[TB] reset");
    repeat (2) applyStimulus(0, 0, 0, 0, 3'b000, 0, 3'b000);

    $display("[TB] fill column with up arrows");
    repeat (26 * TPS) applyStimulus(1, 0, 1, 1, 3'b001, 0, 3'b000);
    applyStimulus(1, 1, 1, 1, 3'b001, 0, 3'b000);

    $display("[TB] single left arrow to bottom, excellent");
    loadArrow(3'b010);
    waitSlot(25, 2);
    applyStimulus(1, 0, 1, 0, 3'b000, 1, 3'b010);
    idle(2);
    applyStimulus(1, 0, 1, 0, 3'b000, 1, 3'b011);
    idle(HOLD + 2);

    $display("[TB] right arrow in slot 23, good");
    loadArrow(3'b100);
    waitSlot(23, 4);
    applyStimulus(1, 0, 1, 0, 3'b000, 1, 3'b100);
    idle(3);

    $display("[TB] shake miss, then shake hit on step cycle");
    loadArrow(3'b110);
    waitSlot(25, 6);
    idle(2 * TPS);
    loadArrow(3'b110);
    waitSlot(25, 6);
    repeat (TPS) if (stepCnt != TPS - 1) idle(1);
    applyStimulus(1, 0, 1, 0, 3'b000, 1, 3'b110);
    idle(HOLD + 2);

    $display("[TB] async reset mid-step, then clear");
    repeat (6) applyStimulus(1, 0, 1, 1, 3'b011, 0, 3'b000);
    applyStimulus(0, 0, 1, 1, 3'b011, 0, 3'b000);
    repeat (9) applyStimulus(1, 0, 1, 1, 3'b011, 0, 3'b000);
    applyStimulus(1, 1, 1, 1, 3'b011, 0, 3'b000);
    idle(2);

    $display("[TB] combo saturation run");
    for (int i = 0; i < 300 * TPS; i++) begin
      pv = (stepCnt == TPS - 1);
      applyStimulus(1, 0, 1, 1, 3'b001, pv, 3'b001);
    end

    $display("[TB] randomized run");
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      cv = 1'($urandom_range(0, 1));
      ca = 3'($urandom_range(0, 7));
      pv = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) pl = 3'(lanes[25 - $urandom_range(0, 2)]);
      else pl = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) applyStimulus(1, 1, en, cv, ca, pv, pl);
      else if ($urandom_range(0, 699) == 0) applyStimulus(0, 0, en, cv, ca, pv, pl);
      else applyStimulus(1, 0, en, cv, ca, pv, pl);
    end

    repeat (3) @(posedge clock);
    #2;
    if (expQ.size() != 0) begin
      errors++; checks++;
      $display("[TB] FAIL scoreboard_drain got %0d pending want 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
